// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI-slave / single-port-RAM subsystem.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    // Command codes carried in the top two bits of each frame; decoded by the RAM.
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    // Bits shifted after the rw bit for the default 8-bit payload.
    localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the RAM-side command/readback handshake of the SPI slave.
interface spi_slave_if #(
    parameter int unsigned DATA_W = 8
);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              cmd_err;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, cmd_err
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, cmd_err
    );
endinterface

// File: rtl/spi_miso_shifter.sv
// MISO readback shifter: parallel load, then DATA_W bits MSB first, then idles at 0.
module spi_miso_shifter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o,
    output logic              busy_o
);
    localparam int unsigned CntW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sr_q;
    logic [CntW-1:0]   cnt_q;
    logic              miso_q;

    // Load, then present one bit per clock; the load cycle itself still drives 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            miso_q <= 1'b0;
        end else if (clear_i) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            miso_q <= 1'b0;
        end else if (load_i) begin
            sr_q   <= data_i;
            cnt_q  <= CntW'(DATA_W);
            miso_q <= 1'b0;
        end else if (cnt_q != '0) begin
            miso_q <= sr_q[DATA_W-1];
            sr_q   <= sr_q << 1;
            cnt_q  <= cnt_q - CntW'(1);
        end else begin
            miso_q <= 1'b0;
        end
    end

    assign miso_o = miso_q;
    assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: deserialises rw + command frames for the RAM and
// serialises RAM read data back on MISO.
// Optional build macro SPI_SLAVE_CMD_CHECK_EN enables command-code checking (cmd_err).
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input logic       clk,
    input logic       rst_n,
    spi_slave_if.slave bus
);
    localparam int unsigned FrameW = DATA_W + 2;
    localparam int unsigned CntW   = $clog2(FrameW + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FrameW - 1);
    localparam logic [CntW-1:0] CntDone = CntW'(FrameW);

    spi_state_e        state_q;
    logic [CntW-1:0]   cnt_q;
    logic [FrameW-1:0] sh_q;
    logic [FrameW-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              rd_addr_seen_q;
    logic              rd_wait_q;     // READ_DATA frame done, waiting for tx_valid
    logic [FrameW-1:0] word_w;
    logic              cmd_ok;
    logic              abort;
    logic              shift_busy;
    logic              shift_load;

    assign word_w = {sh_q[FrameW-2:0], bus.MOSI};
    assign abort  = (state_q != IDLE) && bus.SS_n;

`ifdef SPI_SLAVE_CMD_CHECK_EN
    logic rw_q;
    logic cmd_err_q;

    // Code MSB must echo the rw bit; read frames must carry the matching read code.
    always_comb begin
        cmd_ok = (word_w[FrameW-1] == rw_q);
        if (state_q == READ_ADD)  cmd_ok = cmd_ok && (word_w[FrameW-1 -: 2] == RD_ADDR);
        if (state_q == READ_DATA) cmd_ok = cmd_ok && (word_w[FrameW-1 -: 2] == RD_DATA);
    end

    assign bus.cmd_err = cmd_err_q;
`else
    assign cmd_ok      = 1'b1;
    assign bus.cmd_err = 1'b0;
`endif

    // Frame FSM with registered rx outputs and read-address tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sh_q           <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            rd_wait_q      <= 1'b0;
`ifdef SPI_SLAVE_CMD_CHECK_EN
            rw_q           <= 1'b0;
            cmd_err_q      <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_CMD_CHECK_EN
            cmd_err_q  <= 1'b0;
`endif
            if (abort) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                sh_q      <= '0;
                rd_wait_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (!bus.SS_n) state_q <= CHK_CMD;
                    end
                    CHK_CMD: begin
`ifdef SPI_SLAVE_CMD_CHECK_EN
                        rw_q <= bus.MOSI;
`endif
                        if (!bus.MOSI)          state_q <= WRITE;
                        else if (rd_addr_seen_q) state_q <= READ_DATA;
                        else                    state_q <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (cnt_q != CntDone) begin
                            sh_q  <= word_w;
                            cnt_q <= cnt_q + CntW'(1);
                            if (cnt_q == CntLast) begin
                                if (cmd_ok) begin
                                    rx_data_q  <= word_w;
                                    rx_valid_q <= 1'b1;
                                    if (state_q == READ_ADD) rd_addr_seen_q <= 1'b1;
                                    if (state_q == READ_DATA) begin
                                        rd_addr_seen_q <= 1'b0;
                                        rd_wait_q      <= 1'b1;
                                    end
                                end else begin
`ifdef SPI_SLAVE_CMD_CHECK_EN
                                    cmd_err_q <= 1'b1;
`endif
                                end
                            end
                        end else if (shift_load) begin
                            rd_wait_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign shift_load = rd_wait_q && bus.tx_valid && (state_q == READ_DATA) && !bus.SS_n
                        && !shift_busy;

    spi_miso_shifter #(
        .DATA_W (DATA_W)
    ) u_miso_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (shift_load),
        .clear_i (abort),
        .data_i  (bus.tx_data),
        .miso_o  (bus.MISO),
        .busy_o  (shift_busy)
    );

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: write/read frames, readback, abort, async reset,
// and command checking (behaviour follows SPI_SLAVE_CMD_CHECK_EN).
module tb_spi_slave;
    import spi_slave_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rxv_cnt = 0;
    int   exp_pulses = 0;
    logic [7:0] rb;

    spi_slave_if #(.DATA_W(8)) bus ();

    spi_slave #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count every cycle in which rx_valid is seen high.
    always @(negedge clk) if (bus.rx_valid === 1'b1) rxv_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ss, input logic mosi);
        @(negedge clk);
        bus.SS_n = ss;
        bus.MOSI = mosi;
    endtask

    // IDLE cycle, rw bit, then 10 bits MSB first; checks the state picked by the rw bit.
    task automatic send_frame(input logic rw, input logic [9:0] w, input spi_state_e exp_st,
                              input string tag);
        drive(1'b0, 1'b0);
        drive(1'b0, rw);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            if (i == 9) check_eq({tag, "_state"}, 32'(dut.state_q), 32'(exp_st));
            bus.SS_n = 1'b0;
            bus.MOSI = w[i];
        end
        @(negedge clk);
    endtask

    task automatic end_frame();
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0;

        // Reset values
        @(negedge clk);
        check_eq("rst_rx_data", 32'(bus.rx_data), 32'h0);
        check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
        check_eq("rst_miso", 32'(bus.MISO), 32'h0);
        check_eq("rst_cmd_err", 32'(bus.cmd_err), 32'h0);
        check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("rst_seen", 32'(dut.rd_addr_seen_q), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write address; trailing bits and a stray tx_valid are ignored
        send_frame(1'b0, 10'h0A5, WRITE, "wa");
        exp_pulses++;
        check_eq("wa_rx_valid", 32'(bus.rx_valid), 32'h1);
        check_eq("wa_rx_data", 32'(bus.rx_data), 32'h0A5);
        bus.MOSI = 1'b1;
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        check_eq("wa_rx_valid_drop", 32'(bus.rx_valid), 32'h0);
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.MOSI = ~bus.MOSI;
            @(negedge clk);
            check_eq("wa_miso_quiet", 32'(bus.MISO), 32'h0);
        end
        check_eq("wa_rx_data_hold", 32'(bus.rx_data), 32'h0A5);
        end_frame();

        // Write data leaves rd_addr_seen clear
        send_frame(1'b0, 10'h13C, WRITE, "wd");
        exp_pulses++;
        check_eq("wd_rx_valid", 32'(bus.rx_valid), 32'h1);
        check_eq("wd_rx_data", 32'(bus.rx_data), 32'h13C);
        check_eq("wd_seen", 32'(dut.rd_addr_seen_q), 32'h0);
        end_frame();

        // Read address then read data with MISO readback
        send_frame(1'b1, 10'h207, READ_ADD, "ra");
        exp_pulses++;
        check_eq("ra_rx_valid", 32'(bus.rx_valid), 32'h1);
        check_eq("ra_rx_data", 32'(bus.rx_data), 32'h207);
        check_eq("ra_seen", 32'(dut.rd_addr_seen_q), 32'h1);
        end_frame();

        send_frame(1'b1, 10'h3A5, READ_DATA, "rd");
        exp_pulses++;
        check_eq("rd_rx_valid", 32'(bus.rx_valid), 32'h1);
        check_eq("rd_rx_data", 32'(bus.rx_data), 32'h3A5);
        check_eq("rd_seen", 32'(dut.rd_addr_seen_q), 32'h0);
        bus.tx_data = 8'hC3;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check_eq("rd_miso_load", 32'(bus.MISO), 32'h0);
        rb = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            check_eq($sformatf("rd_miso_b%0d", i), 32'(bus.MISO), 32'(rb[i]));
        end
        @(negedge clk);
        check_eq("rd_miso_after", 32'(bus.MISO), 32'h0);
        end_frame();

        // Abort after 6 bits of a write, then a full frame
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        @(negedge clk);
        check_eq("ab_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("ab_rx_valid", 32'(bus.rx_valid), 32'h0);
        send_frame(1'b0, 10'h1F0, WRITE, "ab2");
        exp_pulses++;
        check_eq("ab2_rx_valid", 32'(bus.rx_valid), 32'h1);
        check_eq("ab2_rx_data", 32'(bus.rx_data), 32'h1F0);
        end_frame();

        // Async reset mid readback
        send_frame(1'b1, 10'h2F0, READ_ADD, "ar1");
        exp_pulses++;
        end_frame();
        send_frame(1'b1, 10'h300, READ_DATA, "ar2");
        exp_pulses++;
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        check_eq("ar_miso_pre", 32'(bus.MISO), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_miso", 32'(bus.MISO), 32'h0);
        check_eq("ar_rx_valid", 32'(bus.rx_valid), 32'h0);
        check_eq("ar_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        bus.SS_n = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        // Async reset while rd_addr_seen and rx_valid are set
        send_frame(1'b1, 10'h2AA, READ_ADD, "ar3");
        exp_pulses++;
        check_eq("ar3_rx_valid_pre", 32'(bus.rx_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar3_rx_valid", 32'(bus.rx_valid), 32'h0);
        check_eq("ar3_rx_data", 32'(bus.rx_data), 32'h0);
        check_eq("ar3_seen", 32'(dut.rd_addr_seen_q), 32'h0);
        @(negedge clk);
        bus.SS_n = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        // Read frame carrying a write code
        send_frame(1'b1, 10'h101, READ_ADD, "cc");
`ifdef SPI_SLAVE_CMD_CHECK_EN
        check_eq("cc_rx_valid", 32'(bus.rx_valid), 32'h0);
        check_eq("cc_cmd_err", 32'(bus.cmd_err), 32'h1);
        @(negedge clk);
        check_eq("cc_cmd_err_drop", 32'(bus.cmd_err), 32'h0);
        check_eq("cc_seen", 32'(dut.rd_addr_seen_q), 32'h0);
`else
        exp_pulses++;
        check_eq("cc_rx_valid", 32'(bus.rx_valid), 32'h1);
        check_eq("cc_rx_data", 32'(bus.rx_data), 32'h101);
        check_eq("cc_cmd_err", 32'(bus.cmd_err), 32'h0);
        check_eq("cc_seen", 32'(dut.rd_addr_seen_q), 32'h1);
`endif
        end_frame();
        @(negedge clk);

        check_eq("rx_valid_pulses", 32'(rxv_cnt), 32'(exp_pulses));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Serial front end of the SPI-slave/single-port-RAM subsystem.
- Deserialises MOSI frames into 10-bit command words (2-bit command code + 8-bit payload) and presents them to the RAM as rx_data/rx_valid.
- Captures the RAM's tx_data on tx_valid and serialises it onto MISO during read-data frames.
- Sits directly upstream of the RAM and is the only block driving the RAM's din/rx_valid inputs.

Parameters:
- DATA_W, 8: RAM payload width. rx_data is DATA_W+2 bits; the MISO readback is DATA_W bits.

Ports:
- clk  input  1  system clock; all sampling on the rising edge
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  slave select, active low; frame delimiter
- MOSI  input  1  serial data in, MSB first
- MISO  output  1  serial data out, MSB first
- rx_data  output  DATA_W+2  command word to RAM: [DATA_W+1:DATA_W] is the code, [DATA_W-1:0] is the payload
- rx_valid  output  1  one-cycle strobe, rx_data valid
- tx_data  input  DATA_W  read data from RAM
- tx_valid  input  1  tx_data valid strobe from RAM
- cmd_err  output  1  command-mismatch strobe (see Optional Feature)

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset values:
  - rx_data=0, rx_valid=0, MISO=0, cmd_err=0
  - state=IDLE, bit counter=0, rd_addr_seen=0
- FSM states:
  - IDLE: on SS_n=0 go to CHK_CMD. MOSI is ignored in IDLE.
  - CHK_CMD: sample MOSI as the rw bit. rw=0 goes to WRITE. rw=1 goes to READ_DATA if rd_addr_seen=1, else to READ_ADD.
  - WRITE / READ_ADD / READ_DATA: shift in 10 MOSI bits, MSB first, one per clk.
- Frame length: 1 rw bit + 10 bits = 11 clk cycles with SS_n low before completion.
- Completion:
  - On the edge sampling the 10th bit, the shift register is loaded into rx_data.
  - rx_valid=1 for exactly the following cycle, then 0.
- Flag updates:
  - READ_ADD completion sets rd_addr_seen.
  - READ_DATA completion clears rd_addr_seen.
  - WRITE completion leaves rd_addr_seen unchanged.
- After completion in WRITE or READ_ADD, further MOSI bits are ignored until SS_n=1.
- READ_DATA readback:
  - After completion, wait for tx_valid.
  - On the tx_valid edge, load tx_data into the MISO shift register.
  - On each of the next DATA_W clks, MISO = next bit, MSB first.
  - Afterwards MISO returns to 0.
  - A tx_valid arriving in any other state or phase is ignored.
- Abort: SS_n=1 in any non-IDLE state returns to IDLE on the next edge.
  - Counter cleared, no rx_valid, MISO forced to 0, partial shift discarded.
  - rd_addr_seen is retained.
- A new frame may start the cycle after IDLE is re-entered. Back-to-back frames need SS_n=1 for at least one clk.
- The code bits are not interpreted; they are forwarded as shifted. The RAM decodes them.
- Reset mid-frame: immediate return to reset values, including rd_addr_seen=0.

Optional Feature:
- Macro: SPI_SLAVE_CMD_CHECK_EN.
- When defined, completion checks the code bits:
  - rx_data[DATA_W+1] must equal the rw bit.
  - READ_ADD requires code 2'b10; READ_DATA requires 2'b11.
  - On mismatch: rx_valid is suppressed, cmd_err=1 for one cycle, rd_addr_seen is unchanged, and the FSM waits for SS_n=1.
- When undefined, cmd_err is tied 0 and all frames are forwarded unchecked.

Decomposition:
- shared_pkg gains:
  - typedef enum logic [2:0] spi_state_e {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA}
  - 2-bit command-code localparams: WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11
  - FRAME_BITS=10
- One sub-module, spi_miso_shifter: parallel load on tx_valid, DATA_W-cycle MSB-first shift, busy flag, clear on abort.

Test Plan:
- Write address. SS_n low, MOSI 0 then 00_1010_0101 → rx_valid pulse 1 cycle after 11th bit, rx_data=10'h0A5, MISO stays 0.
- Write data. MOSI 0 then 01_0011_1100 → rx_data=10'h13C, single rx_valid; a subsequent read frame with rd_addr_seen=0 goes to READ_ADD.
- Read sequence:
  - Frame 1: MOSI 1 then 10_0000_0111 → rx_data=10'h207, rd_addr_seen=1.
  - Frame 2: MOSI 1 then 11_xxxx_xxxx; bench drives tx_valid with tx_data=8'hC3 one cycle after rx_valid → MISO 1,1,0,0,0,0,1,1 over next 8 clks, rd_addr_seen=0.
- Abort. SS_n raised after 6 bits of a WRITE → no rx_valid, FSM in IDLE next cycle; a following full frame 0+01_1111_0000 gives rx_data=10'h1F0.
- Async reset. rst_n low mid READ_DATA shift → MISO=0, rx_valid=0, rd_addr_seen=0 immediately, without waiting for a clk edge.
- Command check, SPI_SLAVE_CMD_CHECK_EN defined. MOSI 1 then 01_0000_0001 → no rx_valid, cmd_err pulse 1 cycle. With the macro undefined, the same frame gives rx_valid and rx_data=10'h101.
